// File: rtl/srl_fifo16.sv
// rtl/srl_fifo16.sv - 16-deep shift-register FIFO with optional output register
//
// Purpose : A first-in first-out buffer of 16 words. Each word is held in a shift
//           register: a push shifts every entry up one place and writes the new
//           word at index 0. The oldest word is read from index count-1.
// Ports   : CLK            clock; all state changes on the rising edge
//           RST            synchronous, active-high reset
//           S_DATA/S_VALID write side; a push happens when S_VALID and S_READY are both 1
//           S_READY        1 while there is room for another word
//           M_DATA/M_VALID read side; M_DATA holds the oldest entry
//           M_READY        consumer accepts; a pop happens when M_VALID and M_READY are both 1
//           LEVEL          number of entries held
//           AFULL          1 when LEVEL >= AF_LEVEL
// Config  : SRL_FIFO16_OREG_EN adds a WIDTH-bit output register after the storage.
//           With it, total capacity is 17 and M_VALID rises two cycles after a push
//           into an empty FIFO.

module srl_fifo16 #(
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = 12
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] S_DATA,
   input  logic             S_VALID,
   output logic             S_READY,
   output logic [WIDTH-1:0] M_DATA,
   output logic             M_VALID,
   input  logic             M_READY,
   output logic [4:0]       LEVEL,
   output logic             AFULL
);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       count_q, count_d;
   logic [WIDTH-1:0] srl_mem [16];
   logic [3:0]       rd_addr;
   logic [WIDTH-1:0] srl_out;
   logic             push;
   logic             take;      // one word leaves the shift register this cycle
   logic [4:0]       level_sum;

   assign S_READY = !RST && (state_q != FULL);
   assign push    = S_VALID && S_READY;

   // Entries are never cleared; a reset only forgets how many are valid.
   always_ff @(posedge CLK) begin
      if (push) begin
         srl_mem[0] <= S_DATA;
         for (int i = 1; i < 16; i++) begin
            srl_mem[i] <= srl_mem[i-1];
         end
      end
   end

   // The oldest entry sits at count-1. On a push with a pop in the same cycle,
   // the count does not change, and the shift moves the next-oldest word into that slot.
   assign rd_addr = (count_q == 5'd0) ? 4'd0 : 4'(count_q - 5'd1);
   assign srl_out = srl_mem[rd_addr];

`ifdef SRL_FIFO16_OREG_EN
   logic [WIDTH-1:0] oreg_data;
   logic             oreg_valid;
   logic             pop;

   assign pop  = !RST && oreg_valid && M_READY;
   // Refill the output register whenever it will be free after this edge.
   assign take = !RST && (state_q != EMPTY) && (!oreg_valid || M_READY);

   always_ff @(posedge CLK) begin
      if (RST) begin
         oreg_valid <= 1'b0;
      end else if (take) begin
         oreg_valid <= 1'b1;
      end else if (pop) begin
         oreg_valid <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (take) begin
         oreg_data <= srl_out;
      end
   end

   assign M_VALID   = !RST && oreg_valid;
   assign M_DATA    = oreg_data;
   assign level_sum = count_q + {4'd0, oreg_valid};
`else
   assign M_VALID   = !RST && (state_q != EMPTY);
   assign M_DATA    = srl_out;
   assign take      = M_VALID && M_READY;
   assign level_sum = count_q;
`endif

   always_ff @(posedge CLK) begin
      state_q <= state_d;
      count_q <= count_d;
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (RST) begin
         state_d = EMPTY;
         count_d = 5'd0;
      end else begin
         case ({push, take})
            2'b10: begin
               count_d = count_q + 5'd1;
               state_d = (count_q == 5'd15) ? FULL : PARTIAL;
            end
            2'b01: begin
               count_d = count_q - 5'd1;
               state_d = (count_q == 5'd1) ? EMPTY : PARTIAL;
            end
            default: begin
               state_d = state_q;
               count_d = count_q;
            end
         endcase
      end
   end

   assign LEVEL = RST ? 5'd0 : level_sum;
   assign AFULL = !RST && (level_sum >= 5'(AF_LEVEL));

endmodule

// File: tb/tb_srl_fifo16.sv
// tb/tb_srl_fifo16.sv - directed bench for srl_fifo16

module tb_srl_fifo16;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] S_DATA;
   logic       S_VALID;
   logic       S_READY;
   logic [7:0] M_DATA;
   logic       M_VALID;
   logic       M_READY;
   logic [4:0] LEVEL;
   logic       AFULL;

   int checks = 0;
   int errors = 0;

   srl_fifo16 #(.WIDTH(8), .AF_LEVEL(12)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .S_DATA (S_DATA),
      .S_VALID(S_VALID),
      .S_READY(S_READY),
      .M_DATA (M_DATA),
      .M_VALID(M_VALID),
      .M_READY(M_READY),
      .LEVEL  (LEVEL),
      .AFULL  (AFULL)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      RST = 1'b1; S_VALID = 1'b0; S_DATA = 8'h00; M_READY = 1'b0;
      step(); step();
      chk("rst_sready", 32'(S_READY), 0);
      chk("rst_mvalid", 32'(M_VALID), 0);
      chk("rst_level",  32'(LEVEL),   0);
      chk("rst_afull",  32'(AFULL),   0);
      RST = 1'b0;
      step();
      chk("post_rst_sready", 32'(S_READY), 1);
      chk("post_rst_level",  32'(LEVEL),   0);
      chk("post_rst_mvalid", 32'(M_VALID), 0);

`ifdef SRL_FIFO16_OREG_EN
      // Two-cycle latency through the output register.
      S_VALID = 1'b1; S_DATA = 8'h5A;
      step();
      S_VALID = 1'b0;
      chk("oreg_lat_k_mvalid", 32'(M_VALID), 0);
      chk("oreg_lat_k_level",  32'(LEVEL),   1);
      step();
      chk("oreg_lat_k1_mvalid", 32'(M_VALID), 1);
      chk("oreg_lat_k1_mdata",  32'(M_DATA),  32'h5A);
      chk("oreg_lat_k1_level",  32'(LEVEL),   1);
      // Fill to 17: the register holds 0x5A, storage takes 16 more.
      for (int i = 0; i < 16; i++) begin
         S_VALID = 1'b1; S_DATA = 8'(8'h60 + i);
         step();
         chk("oreg_fill_level", 32'(LEVEL), 32'(i + 2));
      end
      chk("oreg_full_sready", 32'(S_READY), 0);
      chk("oreg_full_afull",  32'(AFULL),   1);
      S_DATA = 8'hEE;
      step();
      S_VALID = 1'b0;
      chk("oreg_no_overflow", 32'(LEVEL), 17);
      M_READY = 1'b1;
      for (int i = 0; i < 17; i++) begin
         chk("oreg_drain_mvalid", 32'(M_VALID), 1);
         chk("oreg_drain_data", 32'(M_DATA), (i == 0) ? 32'h5A : 32'(8'h60 + i - 1));
         step();
      end
      M_READY = 1'b0;
      chk("oreg_drained_mvalid", 32'(M_VALID), 0);
      chk("oreg_drained_level",  32'(LEVEL),   0);
`else
      // Three back-to-back pushes with the consumer stalled.
      S_VALID = 1'b1; S_DATA = 8'h11;
      step();
      chk("lat1_mvalid", 32'(M_VALID), 1);
      chk("lat1_mdata",  32'(M_DATA),  32'h11);
      S_DATA = 8'h22; step();
      S_DATA = 8'h33; step();
      S_VALID = 1'b0;
      chk("three_level",  32'(LEVEL),   3);
      chk("three_mdata",  32'(M_DATA),  32'h11);
      chk("three_mvalid", 32'(M_VALID), 1);
      chk("three_afull",  32'(AFULL),   0);
      M_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("three_drain", 32'(M_DATA), 32'(8'h11 * (i + 1)));
         step();
      end
      chk("three_empty_mvalid", 32'(M_VALID), 0);
      step();
      chk("pop_on_empty_ignored", 32'(LEVEL), 0);
      M_READY = 1'b0;

      // Fill all 16 slots, then try to overflow.
      for (int i = 0; i < 16; i++) begin
         S_VALID = 1'b1; S_DATA = 8'(i);
         step();
         chk("fill_level",  32'(LEVEL),   32'(i + 1));
         chk("fill_afull",  32'(AFULL),   32'((i + 1) >= 12));
         chk("fill_sready", 32'(S_READY), 32'(i < 15));
      end
      S_DATA = 8'hEE;
      step();
      S_VALID = 1'b0;
      chk("no_overflow_level", 32'(LEVEL), 16);
      M_READY = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain16_data", 32'(M_DATA), 32'(i));
         step();
      end
      M_READY = 1'b0;
      chk("drain16_empty", 32'(M_VALID), 0);

      // Hold level 5 while streaming push+pop for 10 cycles.
      for (int i = 0; i < 5; i++) begin
         S_VALID = 1'b1; S_DATA = 8'(8'h40 + i);
         step();
      end
      chk("stream_start_level", 32'(LEVEL), 5);
      M_READY = 1'b1;
      for (int c = 0; c < 10; c++) begin
         S_DATA = 8'(8'h45 + c);
         chk("stream_data", 32'(M_DATA), 32'(8'h40 + c));
         step();
         chk("stream_level", 32'(LEVEL), 5);
      end
      S_VALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stream_tail", 32'(M_DATA), 32'(8'h4A + i));
         step();
      end
      M_READY = 1'b0;
      chk("stream_empty", 32'(LEVEL), 0);

      // Reset at level 8 with a push pending.
      for (int i = 0; i < 8; i++) begin
         S_VALID = 1'b1; S_DATA = 8'(8'h80 + i);
         step();
      end
      chk("pre_rst_level", 32'(LEVEL), 8);
      RST = 1'b1; S_DATA = 8'h77;
      step();
      chk("midrst_level",  32'(LEVEL),   0);
      chk("midrst_mvalid", 32'(M_VALID), 0);
      chk("midrst_sready", 32'(S_READY), 0);
      RST = 1'b0; S_VALID = 1'b0;
      #1;
      chk("after_rst_level", 32'(LEVEL), 0);
      step();
      S_VALID = 1'b1; S_DATA = 8'hA5;
      step();
      S_VALID = 1'b0;
      chk("a5_mvalid", 32'(M_VALID), 1);
      chk("a5_mdata",  32'(M_DATA),  32'hA5);
      chk("a5_level",  32'(LEVEL),   1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/srl_fifo16.md
SRL_FIFO16 -- requirements
Module: srl_fifo16

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, legal 1..64.
REQ-002 SHALL have parameter AF_LEVEL, default 12: almost-full threshold, legal 1..16.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port S_DATA  input  WIDTH  write data.
REQ-006 SHALL have port S_VALID  input  1  write request.
REQ-007 SHALL have port S_READY  output  1  space available; push = S_VALID & S_READY.
REQ-008 SHALL have port M_DATA  output  WIDTH  oldest entry.
REQ-009 SHALL have port M_VALID  output  1  M_DATA holds a valid entry.
REQ-010 SHALL have port M_READY  input  1  consumer accept; pop = M_VALID & M_READY.
REQ-011 SHALL have port LEVEL  output  5  total entries held, 0..16 (0..17 with output register).
REQ-012 SHALL have port AFULL  output  1  LEVEL >= AF_LEVEL.

Function
REQ-013 Storage SHALL be WIDTH 16-bit shift registers, shift-in at index 0 on push only, newest at index 0, no reset of contents, power-up zero.
REQ-014 Read address SHALL be count-1 when count>0, 0 when count=0; M_DATA SHALL be combinational storage read at that address (no output register build).
REQ-015 Control SHALL use explicit states EMPTY (count=0), PARTIAL (1..15), FULL (16).
REQ-016 Push only: count+1; EMPTY->PARTIAL, PARTIAL->FULL at 15->16.
REQ-017 Pop only: count-1; FULL->PARTIAL, PARTIAL->EMPTY at 1->0.
REQ-018 Simultaneous push and pop: count and state unchanged, read address unchanged, popped word is the pre-shift oldest.
REQ-019 S_READY SHALL be 1 iff state != FULL and RST=0; push while FULL impossible by construction.
REQ-020 M_VALID SHALL be 1 iff state != EMPTY; M_READY while EMPTY SHALL be ignored.
REQ-021 Latency: word pushed at edge k SHALL appear on M_DATA with M_VALID=1 after edge k (1 cycle) when FIFO was empty.
REQ-022 Ordering SHALL be strict FIFO; no data loss or duplication under any push/pop pattern.
REQ-023 LEVEL and AFULL SHALL be registered-state-derived, updated same edge as count.

Reset
REQ-024 RST=1 at an edge SHALL force count=0, state EMPTY, output register empty; storage contents unchanged.
REQ-025 While RST=1: S_READY=0, M_VALID=0, LEVEL=0, AFULL=0; S_VALID/M_READY ignored.
REQ-026 Reset mid-operation SHALL discard all held entries; first push after release is first word out.

Configuration
REQ-027 Macro SRL_FIFO16_OREG_EN SHALL, when defined, add a WIDTH-bit output register after storage; M_DATA/M_VALID driven from it.
REQ-028 With OREG: register loads storage oldest when (empty or popped) and count>0; capacity 17; LEVEL = count + reg valid; S_READY depends only on count<16.
REQ-029 With OREG: empty-FIFO push at edge k SHALL give M_VALID=1 after edge k+1 (2 cycles); sustained push+pop SHALL sustain 1 word/cycle.
REQ-030 Without macro: REQ-014/021 timing exactly; no extra register.

Verification
REQ-031 Reset, push 0x11,0x22,0x33 back-to-back, M_READY=0 -> LEVEL=3, M_DATA=0x11, M_VALID=1, AFULL=0.
REQ-032 Push 16 words 0x00..0x0F, no pops -> S_READY=0 after 16th edge, LEVEL=16, AFULL=1 from 12th push; 17th S_VALID not accepted; drain yields 0x00..0x0F in order.
REQ-033 LEVEL=5, S_VALID=M_READY=1 for 10 cycles, incrementing data -> LEVEL stays 5, output sequence contiguous, no gaps.
REQ-034 LEVEL=8, assert RST one cycle with S_VALID=1 -> LEVEL=0, M_VALID=0, next push 0xA5 emerges first with 1-cycle latency.
REQ-035 With SRL_FIFO16_OREG_EN: empty, push 0x5A at edge k -> M_VALID=1 after edge k+1; fill to LEVEL=17, S_READY=0; drain 17 words in order.
